fifo_wr_arbiter: RTL and testbench

Round-robin, packet-aware arbiter that shares one sync_fifo write port among NUM_REQ requesters.
- Each requester offers words with a valid/ready handshake and a last flag.
- Once a requester wins, it keeps the write port until its last word is written, so packets never interleave in the FIFO.
- Sits directly in front of sync_fifo: drives wr_en_i/wdata_i and observes wfull_o.

---
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one sync_fifo write port among NUM_REQ requesters.
// A winner keeps the port until its last word is written, so packets never interleave.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          resetn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    input  logic                          fifo_wfull_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          locked_o
);

    localparam int unsigned CandWidth = IDX_WIDTH + 1;

    typedef enum logic {StIdle, StLocked} state_e;

    state_e                 r_state, state_d;
    logic                   r_run;
    logic [IDX_WIDTH-1:0]   r_ptr, ptr_d;
    logic [IDX_WIDTH-1:0]   r_owner, owner_d;

    logic                   gnt_vld;
    logic [IDX_WIDTH-1:0]   gnt_idx;
    logic [CandWidth-1:0]   cand;
    logic                   xfer;

    // Rotating priority search starting at r_ptr; the extra bit of cand absorbs the wrap sum.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (r_run) begin
            if (r_state == StLocked) begin
                gnt_vld = 1'b1;
                gnt_idx = r_owner;
            end else begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    cand = {1'b0, r_ptr} + CandWidth'(i);
                    if (cand >= CandWidth'(NUM_REQ)) begin
                        cand = cand - CandWidth'(NUM_REQ);
                    end
                    if (!gnt_vld && req_valid_i[cand[IDX_WIDTH-1:0]]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = cand[IDX_WIDTH-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        grant_o      = '0;
        req_ready_o  = '0;
        fifo_wdata_o = '0;
        xfer         = 1'b0;
        if (gnt_vld) begin
            grant_o[gnt_idx]     = 1'b1;
            req_ready_o[gnt_idx] = ~fifo_wfull_i;
            fifo_wdata_o         = req_data_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            xfer                 = req_valid_i[gnt_idx] & ~fifo_wfull_i;
        end
    end

    assign fifo_wr_en_o = xfer;
    assign locked_o     = (r_state == StLocked);

    // State only moves on an actual word transfer; stalls and idle owners hold everything.
    always_comb begin
        state_d = r_state;
        ptr_d   = r_ptr;
        owner_d = r_owner;
        if (xfer) begin
            if (req_last_i[gnt_idx]) begin
                state_d = StIdle;
                ptr_d   = (gnt_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_WIDTH'(1);
            end else begin
                state_d = StLocked;
                owner_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_run   <= 1'b0;
            r_state <= StIdle;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= state_d;
            r_ptr   <= ptr_d;
            r_owner <= owner_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, reset and NUM_REQ=3 sequences,
// then randomized traffic checked against a packet-level reference model.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic [3:0]  valid = '0, last = '0, ready, grant;
    logic [63:0] data = '0;
    logic        wr_en, full = 1'b0, locked;
    logic [15:0] wdata;

    logic [2:0]  valid3 = '0, last3 = '0, ready3, grant3;
    logic [47:0] data3 = '0;
    logic        wr3, full3 = 1'b0, locked3;
    logic [15:0] wdata3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .req_valid_i(valid), .req_data_i(data), .req_last_i(last), .req_ready_o(ready),
        .fifo_wr_en_o(wr_en), .fifo_wdata_o(wdata), .fifo_wfull_i(full),
        .grant_o(grant), .locked_o(locked)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(16)) dut3 (
        .clk_i(clk), .resetn_i(resetn),
        .req_valid_i(valid3), .req_data_i(data3), .req_last_i(last3), .req_ready_o(ready3),
        .fifo_wr_en_o(wr3), .fifo_wdata_o(wdata3), .fifo_wfull_i(full3),
        .grant_o(grant3), .locked_o(locked3)
    );

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       f;
        logic [3:0] g;
        logic [3:0] r;
        logic       w;
        logic       lk;
    } vec_t;

    vec_t tbl[26];

    function automatic logic [15:0] word(int k, int i);
        return {4'(k), 12'(i)};
    endfunction

    function automatic int idx_of(logic [3:0] oh);
        int r = 0;
        for (int k = 0; k < 4; k++) if (oh[k]) r = k;
        return r;
    endfunction

    task automatic load_words(int tag);
        for (int k = 0; k < 4; k++) data[k*16 +: 16] = word(k, tag);
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [3:0] er,
                         input logic ew, input logic [15:0] ed, input logic el);
        checks++;
        if ({grant, ready, wr_en, wdata, locked} !== {eg, er, ew, ed, el}) begin
            failures++;
            $display("FAIL %s: got grant=%b ready=%b wr=%b wdata=%h locked=%b, want grant=%b ready=%b wr=%b wdata=%h locked=%b",
                     name, grant, ready, wr_en, wdata, locked, eg, er, ew, ed, el);
        end
    endtask

    // Reference model state: running flag, packet owner (-1 = none), rotation start.
    int m_owner, m_ptr, g;
    bit m_run, xfer;
    logic [3:0]  eg, er;
    logic [15:0] ed;

    initial begin
        //        valid    last     full  grant    ready    wr    locked
        tbl[0]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0};
        tbl[6]  = '{4'b0011, 4'b0011, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0};
        tbl[7]  = '{4'b0011, 4'b0010, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0};
        tbl[8]  = '{4'b0011, 4'b0010, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1};
        tbl[9]  = '{4'b0011, 4'b0011, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1};
        tbl[10] = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0};
        tbl[11] = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0};
        tbl[12] = '{4'b0111, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1};
        tbl[13] = '{4'b0111, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1};
        tbl[14] = '{4'b0111, 4'b0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1};
        tbl[15] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1};
        tbl[16] = '{4'b1001, 4'b0000, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0};
        tbl[17] = '{4'b0001, 4'b0000, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1};
        tbl[18] = '{4'b0001, 4'b0000, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1};
        tbl[19] = '{4'b0001, 4'b0000, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1};
        tbl[20] = '{4'b0001, 4'b0000, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b1};
        tbl[21] = '{4'b1001, 4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1};
        tbl[22] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0};
        tbl[23] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0};
        tbl[24] = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0};
        tbl[25] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 26; i++) begin
            valid = tbl[i].v;
            last  = tbl[i].l;
            full  = tbl[i].f;
            load_words(i);
            #3;
            check($sformatf("vec%0d", i), tbl[i].g, tbl[i].r, tbl[i].w,
                  (tbl[i].g == 4'b0000) ? 16'h0000 : word(idx_of(tbl[i].g), i), tbl[i].lk);
            @(posedge clk); #1;
        end

        // Async reset in the middle of a packet from req1 (r_ptr is 2 here).
        valid = 4'b0010; last = 4'b0000; load_words(100);
        #3 check("rst_first_word", 4'b0010, 4'b0010, 1'b1, word(1, 100), 1'b0);
        @(posedge clk); #1;
        check("rst_locked", 4'b0010, 4'b0010, 1'b1, word(1, 100), 1'b1);
        #1 resetn = 1'b0;
        #1 check("rst_async", 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        valid = 4'b1111; last = 4'b1111; load_words(200);
        #3 check("rst_run0", 4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
        @(posedge clk); #1;
        #2 check("rst_restart", 4'b0001, 4'b0001, 1'b1, word(0, 200), 1'b0);
        @(posedge clk); #1;
        valid = '0; last = '0;

        // NUM_REQ=3: rotation must wrap 2 -> 0.
        valid3 = 3'b111; last3 = 3'b111;
        for (int j = 0; j < 7; j++) begin
            for (int k = 0; k < 3; k++) data3[k*16 +: 16] = word(k, 300 + j);
            #3;
            checks++;
            if (grant3 !== 3'(1 << (j % 3)) || wr3 !== 1'b1 || ready3 !== grant3 ||
                wdata3 !== word(j % 3, 300 + j)) begin
                failures++;
                $display("FAIL n3_rr%0d: got grant=%b wr=%b ready=%b wdata=%h, want grant=%b wr=1 wdata=%h",
                         j, grant3, wr3, ready3, wdata3, 3'(1 << (j % 3)), word(j % 3, 300 + j));
            end
            @(posedge clk); #1;
        end
        valid3 = '0;

        // Randomized traffic against the reference model, starting from a fresh reset.
        resetn = 1'b0;
        #2 resetn = 1'b1;
        m_run = 1'b0; m_owner = -1; m_ptr = 0;
        valid = '0; last = '0; full = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            #2;
            g = -1;
            if (m_run) begin
                if (m_owner >= 0) g = m_owner;
                else for (int k = 0; k < 4; k++)
                    if (g < 0 && valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
            eg   = (g < 0) ? 4'b0000 : 4'(1 << g);
            er   = (g >= 0 && !full) ? eg : 4'b0000;
            xfer = (g >= 0) && valid[g] && !full;
            ed   = (g < 0) ? 16'h0000 : data[g*16 +: 16];
            check($sformatf("rand%0d", c), eg, er, xfer, ed, m_owner >= 0);
            @(posedge clk);
            m_run = 1'b1;
            if (xfer) begin
                if (last[g]) begin
                    m_owner = -1;
                    m_ptr   = (g + 1) % 4;
                end else begin
                    m_owner = g;
                end
            end
            #1;
            // Requesters hold their word until it is accepted, then pick a new one.
            for (int k = 0; k < 4; k++) begin
                if (!valid[k] || (xfer && g == k)) begin
                    valid[k]          = ($urandom_range(0, 2) != 0);
                    last[k]           = ($urandom_range(0, 2) == 0);
                    data[k*16 +: 16]  = 16'($urandom);
                end
            end
            full = ($urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
